// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared constants for the AL422B frame FIFO read path.
// State encoding, default frame geometry and pointer-reset length.
package ov7670_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RRST  = 3'd1;
  localparam logic [2:0] RD_HI = 3'd2;
  localparam logic [2:0] RD_LO = 3'd3;
  localparam logic [2:0] PUSH  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = IDLE,
    S_RRST  = RRST,
    S_RD_HI = RD_HI,
    S_RD_LO = RD_LO,
    S_PUSH  = PUSH,
    S_DONE  = DONE
  } state_t;

  localparam int DEF_H_PIX    = 320;
  localparam int DEF_V_LINE   = 240;
  localparam int DEF_RCLK_DIV = 2;

  localparam int RRST_PERIODS = 4;

  // Counter width able to hold 0..n-1, never below one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ov7670_rclk_gen.sv
// ov7670_rclk_gen: AL422B read clock, RCLK_DIV cycles low then high.
// i_en runs it; o_rclk drives RCLK; o_sample_stb marks last high cycle.
module ov7670_rclk_gen
  import ov7670_pkg::*;
#(
  parameter int RCLK_DIV = DEF_RCLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_rclk,
  output logic o_sample_stb
);

  localparam int CW = cnt_width(2 * RCLK_DIV);
  localparam logic [CW-1:0] C_LAST = CW'(2 * RCLK_DIV - 1);
  localparam logic [CW-1:0] C_HI   = CW'(RCLK_DIV);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_rclk;

  // Phase counter wraps every period and falls to zero when disabled,
  // so each enable burst starts at the beginning of a low phase.
  always_comb begin
    w_cnt_nxt = '0;
    if (i_en && (r_cnt != C_LAST))
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_rclk <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_rclk <= (w_cnt_nxt >= C_HI);
    end
  end

  assign o_rclk       = r_rclk;
  assign o_sample_stb = i_en && (r_cnt == C_LAST);

endmodule

// File: rtl/ov7670_fifo_rd.sv
// ov7670_fifo_rd: reads one RGB565 frame from the AL422B after WR_FRAME
// rises. FIFO_* drive the FIFO; PIX_* is a valid/ready pixel stream.
module ov7670_fifo_rd
  import ov7670_pkg::*;
#(
  parameter int H_PIX    = DEF_H_PIX,
  parameter int V_LINE   = DEF_V_LINE,
  parameter int RCLK_DIV = DEF_RCLK_DIV
) (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic        WR_FRAME,
  input  logic        PIX_READY,
  input  logic [7:0]  FIFO_DATA,
  output logic        FIFO_RCLK,
  output logic        FIFO_RRST,
  output logic        FIFO_OE,
  output logic [15:0] PIX_DATA,
  output logic        PIX_VALID,
  output logic [8:0]  PIX_X,
  output logic [7:0]  PIX_Y,
  output logic        FRAME_DONE,
  output logic        R_IDLE
);

  localparam int RW = cnt_width(RRST_PERIODS);
  localparam logic [RW-1:0] RRST_LAST = RW'(RRST_PERIODS - 1);
  localparam logic [8:0]    X_LAST    = 9'(H_PIX - 1);
  localparam logic [7:0]    Y_LAST    = 8'(V_LINE - 1);

  state_t        r_state;
  logic          r_wr_q;
  logic [RW-1:0] r_rrst_cnt;
  logic          r_rrst_n;
  logic          r_oe_n;
  logic [15:0]   r_data;
  logic          r_valid;
  logic [8:0]    r_x;
  logic [7:0]    r_y;
  logic          r_done;
  logic          r_idle;

  logic w_en;
  logic w_stb;

  assign w_en = (r_state == S_RRST) ||
                (r_state == S_RD_HI) ||
                (r_state == S_RD_LO);

  ov7670_rclk_gen #(
    .RCLK_DIV(RCLK_DIV)
  ) u_rclk (
    .i_clk       (SYS_CLK),
    .i_rst       (RST),
    .i_en        (w_en),
    .o_rclk      (FIFO_RCLK),
    .o_sample_stb(w_stb)
  );

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_wr_q     <= 1'b0;
      r_rrst_cnt <= '0;
      r_rrst_n   <= 1'b1;
      r_oe_n     <= 1'b1;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_done     <= 1'b0;
      r_idle     <= 1'b1;
    end else begin
      r_wr_q <= WR_FRAME;
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          // R_IDLE must drop on this very edge: the write side
          // samples it two cycles after raising WR_FRAME.
          if (WR_FRAME && !r_wr_q) begin
            r_idle     <= 1'b0;
            r_oe_n     <= 1'b0;
            r_rrst_n   <= 1'b0;
            r_rrst_cnt <= '0;
            r_state    <= S_RRST;
          end
        end
        S_RRST: begin
          if (w_stb) begin
            r_rrst_cnt <= r_rrst_cnt + 1'b1;
            if (r_rrst_cnt == RRST_LAST) begin
              r_rrst_n <= 1'b1;
              r_state  <= S_RD_HI;
            end
          end
        end
        S_RD_HI: begin
          if (w_stb) begin
            r_data[15:8] <= FIFO_DATA;
            r_state      <= S_RD_LO;
          end
        end
        S_RD_LO: begin
          if (w_stb) begin
            r_data[7:0] <= FIFO_DATA;
            r_valid     <= 1'b1;
            r_state     <= S_PUSH;
          end
        end
        S_PUSH: begin
          // Coordinates advance together with VALID falling so they
          // always name the pixel currently on PIX_DATA.
          if (PIX_READY) begin
            r_valid <= 1'b0;
            if (r_x < X_LAST) begin
              r_x     <= r_x + 1'b1;
              r_state <= S_RD_HI;
            end else begin
              r_x <= '0;
              if (r_y < Y_LAST) begin
                r_y     <= r_y + 1'b1;
                r_state <= S_RD_HI;
              end else begin
                r_y     <= '0;
                r_state <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_oe_n  <= 1'b1;
          r_idle  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign FIFO_RRST  = r_rrst_n;
  assign FIFO_OE    = r_oe_n;
  assign PIX_DATA   = r_data;
  assign PIX_VALID  = r_valid;
  assign PIX_X      = r_x;
  assign PIX_Y      = r_y;
  assign FRAME_DONE = r_done;
  assign R_IDLE     = r_idle;

endmodule

// File: tb/tb_ov7670_fifo_rd.sv
// tb_ov7670_fifo_rd: two readers (RCLK_DIV 2 and 1) on AL422B models,
// checked against a frame-level pixel/coordinate reference.
module tb_ov7670_fifo_rd;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int NPIX = H * V;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  wr;
  logic [1:0]  rdy;
  logic [1:0]  rclk;
  logic [1:0]  rrst_n;
  logic [1:0]  oe_n;
  logic [1:0]  valid;
  logic [1:0]  done;
  logic [1:0]  idle;
  logic [15:0] pdata [2];
  logic [8:0]  px [2];
  logic [7:0]  py [2];
  logic [7:0]  fd0, fd1;
  logic [7:0]  fin0, fin1;
  logic [7:0]  mem [64];
  int          ptr0 = 0;
  int          ptr1 = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit stall_en = 1'b0;
  bit rnd_rdy  = 1'b0;
  int stall_len = 0;

  int          n [2];
  logic        stl [2];
  logic [32:0] held [2];
  int          hptr [2];
  int          last_acc [2];
  int          done_seen [2];
  logic        pdone [2];

  assign fin0 = oe_n[0] ? 8'h00 : fd0;
  assign fin1 = oe_n[1] ? 8'h00 : fd1;

  ov7670_fifo_rd #(.H_PIX(H), .V_LINE(V), .RCLK_DIV(2)) u0 (
    .SYS_CLK(clk), .RST(rst), .WR_FRAME(wr[0]), .PIX_READY(rdy[0]),
    .FIFO_DATA(fin0), .FIFO_RCLK(rclk[0]), .FIFO_RRST(rrst_n[0]),
    .FIFO_OE(oe_n[0]), .PIX_DATA(pdata[0]), .PIX_VALID(valid[0]),
    .PIX_X(px[0]), .PIX_Y(py[0]), .FRAME_DONE(done[0]),
    .R_IDLE(idle[0])
  );

  ov7670_fifo_rd #(.H_PIX(H), .V_LINE(V), .RCLK_DIV(1)) u1 (
    .SYS_CLK(clk), .RST(rst), .WR_FRAME(wr[1]), .PIX_READY(rdy[1]),
    .FIFO_DATA(fin1), .FIFO_RCLK(rclk[1]), .FIFO_RRST(rrst_n[1]),
    .FIFO_OE(oe_n[1]), .PIX_DATA(pdata[1]), .PIX_VALID(valid[1]),
    .PIX_X(px[1]), .PIX_Y(py[1]), .FRAME_DONE(done[1]),
    .R_IDLE(idle[1])
  );

  // AL422B read port: a rise with RRST low rewinds, otherwise it
  // presents the byte at the pointer and advances.
  always @(posedge rclk[0])
    if (!rrst_n[0]) ptr0 <= 0;
    else begin
      fd0  <= mem[ptr0[5:0]];
      ptr0 <= ptr0 + 1;
    end

  always @(posedge rclk[1])
    if (!rrst_n[1]) ptr1 <= 0;
    else begin
      fd1  <= mem[ptr1[5:0]];
      ptr1 <= ptr1 + 1;
    end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input int i);
    chk("rst_rclk", 64'(rclk[i]), 64'(0));
    chk("rst_rrst", 64'(rrst_n[i]), 64'(1));
    chk("rst_oe", 64'(oe_n[i]), 64'(1));
    chk("rst_data", 64'(pdata[i]), 64'(0));
    chk("rst_valid", 64'(valid[i]), 64'(0));
    chk("rst_x", 64'(px[i]), 64'(0));
    chk("rst_y", 64'(py[i]), 64'(0));
    chk("rst_done", 64'(done[i]), 64'(0));
    chk("rst_idle", 64'(idle[i]), 64'(1));
  endtask

  // Reference: pixel k of a frame is bytes 2k,2k+1 from the rewound
  // FIFO, at column k mod H, line k div H.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int cp;
      cp = (i == 0) ? ptr0 : ptr1;
      if (rst) begin
        n[i]     = 0;
        stl[i]   = 1'b0;
        pdone[i] = 1'b0;
      end else begin
        if (stl[i] && valid[i]) begin
          chk("hold", 64'({pdata[i], px[i], py[i]}), 64'(held[i]));
          chk("hold_ptr", 64'(cp), 64'(hptr[i]));
        end
        if (valid[i]) chk("rclk_push", 64'(rclk[i]), 64'(0));
        if (valid[i] && rdy[i]) begin
          chk("pix", 64'(pdata[i]),
              64'({mem[(2 * n[i]) % 64], mem[(2 * n[i] + 1) % 64]}));
          chk("x", 64'(px[i]), 64'(n[i] % H));
          chk("y", 64'(py[i]), 64'((n[i] / H) % V));
          n[i]++;
          last_acc[i] = cyc;
        end
        if (pdone[i]) chk("done_pulse", 64'(done[i]), 64'(0));
        if (done[i]) begin
          chk("done_lat", 64'(cyc - last_acc[i]), 64'(2));
          chk("done_idle", 64'(idle[i]), 64'(1));
          chk("done_oe", 64'(oe_n[i]), 64'(1));
          done_seen[i]++;
        end
        pdone[i] = done[i];
        stl[i]   = valid[i] && !rdy[i];
        held[i]  = {pdata[i], px[i], py[i]};
        hptr[i]  = cp;
      end
    end
  end

  initial begin
    rdy = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      if (stall_en && valid[0] && px[0] == 9'd2 && py[0] == 8'd0 &&
          stall_len < 10) begin
        rdy[0] = 1'b0;
        stall_len++;
      end else begin
        rdy[0] = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      rdy[1] = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  task automatic start_frame(input int i, input int div);
    int lowc, rises, fv;
    logic pr;
    n[i] = 0;
    wr[i] = 1'b0;
    @(posedge clk);
    #1;
    wr[i] = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_e0", 64'(idle[i]), 64'(0));
    chk("oe_e0", 64'(oe_n[i]), 64'(0));
    chk("rrst_e0", 64'(rrst_n[i]), 64'(0));
    lowc  = 1;
    rises = 0;
    fv    = -1;
    pr    = rclk[i];
    for (int c = 1; c < 40 * div; c++) begin
      @(posedge clk);
      #1;
      if (!rrst_n[i]) begin
        lowc++;
        if (rclk[i] && !pr) rises++;
      end
      pr = rclk[i];
      if (valid[i]) begin
        fv = c;
        break;
      end
    end
    chk("rrst_len", 64'(lowc), 64'(8 * div));
    chk("rrst_rises", 64'(rises), 64'(4));
    chk("first_valid", 64'(fv), 64'(12 * div));
  endtask

  task automatic wait_done(input int i, input int d0);
    int k;
    k = 0;
    while (done_seen[i] == d0 && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("done_timeout", 64'(k < 3000), 64'(1));
    chk("npix", 64'(n[i]), 64'(NPIX));
  endtask

  initial begin
    int d0, k;
    rst = 1'b1;
    wr  = 2'b00;
    done_seen[0] = 0;
    done_seen[1] = 0;
    last_acc[0]  = 0;
    last_acc[1]  = 0;
    for (int j = 0; j < 64; j++) mem[j] = 8'(j);
    #12;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    rst = 1'b0;

    stall_en = 1'b1;
    d0 = done_seen[0];
    start_frame(0, 2);
    repeat (6) @(posedge clk);
    #1;
    wr[0] = 1'b0;
    @(posedge clk);
    #1;
    wr[0] = 1'b1;
    wait_done(0, d0);
    chk("stall_len", 64'(stall_len), 64'(10));
    d0 = done_seen[0];
    repeat (60) @(posedge clk);
    #1;
    chk("no_restart_idle", 64'(idle[0]), 64'(1));
    chk("no_restart_n", 64'(n[0]), 64'(NPIX));
    chk("no_restart_done", 64'(done_seen[0]), 64'(d0));

    stall_en = 1'b0;
    rnd_rdy  = 1'b1;
    repeat (2) begin
      for (int j = 0; j < 64; j++) mem[j] = 8'($urandom);
      d0 = done_seen[0];
      start_frame(0, 2);
      wait_done(0, d0);
    end

    rnd_rdy = 1'b0;
    start_frame(0, 2);
    k = 0;
    while (n[0] != 5 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("abort_reach", 64'(k < 500), 64'(1));
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset(0);
    @(negedge clk);
    rst = 1'b0;
    d0 = done_seen[0];
    start_frame(0, 2);
    wait_done(0, d0);

    rnd_rdy = 1'b1;
    for (int j = 0; j < 64; j++) mem[j] = 8'($urandom);
    d0 = done_seen[1];
    start_frame(1, 1);
    wait_done(1, d0);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ov7670_fifo_rd.md
Name: ov7670_fifo_rd

Overview:
- Read-side controller for the AL422B frame FIFO behind the OV7670. Pairs with the write-side sequencer.
- Starts when the write side reports a complete frame (WR_FRAME rising) and resets the FIFO read pointer.
- Clocks out H_PIX*V_LINE RGB565 pixels as byte pairs and presents them on a valid/ready stream with X/Y coordinates.
- Raises R_IDLE on completion so the write side may capture the next frame.

Parameters:
H_PIX, 320, pixels per line (1..511)
V_LINE, 240, lines per frame (1..255)
RCLK_DIV, 2, SYS_CLK cycles per FIFO_RCLK half-period (>=1)

Ports:
SYS_CLK  in  1  system clock, all logic on rising edge
RST  in  1  asynchronous reset, active-high
WR_FRAME  in  1  level from write sequencer; rising edge = frame stored in FIFO
PIX_READY  in  1  downstream accepts pixel
FIFO_DATA  in  8  AL422B DO[7:0]
FIFO_RCLK  out  1  AL422B read clock
FIFO_RRST  out  1  read-pointer reset, active-low
FIFO_OE  out  1  output enable, active-low
PIX_DATA  out  16  RGB565 pixel; first byte read = [15:8]
PIX_VALID  out  1  PIX_DATA/PIX_X/PIX_Y valid
PIX_X  out  9  column of current pixel
PIX_Y  out  8  line of current pixel
FRAME_DONE  out  1  one-cycle pulse after last pixel accepted
R_IDLE  out  1  high when no read is in progress

Behaviour:
- Reset (async, RST=1): state IDLE. FIFO_RCLK=0, FIFO_RRST=1, FIFO_OE=1, PIX_DATA=0, PIX_VALID=0, PIX_X=0, PIX_Y=0, FRAME_DONE=0, R_IDLE=1. Reset mid-frame aborts immediately; no partial pixel survives.
- WR_FRAME is registered each cycle (wr_q). Start condition is WR_FRAME=1 and wr_q=0, sampled in IDLE. At that start edge E0: R_IDLE<=0, FIFO_OE<=0, FIFO_RRST<=0, state->RRST. R_IDLE must fall on E0, because the write side samples R_IDLE two cycles after raising WR_FRAME.
- A WR_FRAME rising edge outside IDLE is ignored and not queued. A level held high never retriggers.
- RCLK generator: one RCLK period is RCLK_DIV cycles low followed by RCLK_DIV cycles high. sample_stb asserts on the last cycle of the high phase. FIFO_DATA is captured on that edge.
  - Enabled in RRST, RD_HI and RD_LO.
  - Idles low and its phase counter clears when disabled.
- RRST: 4 RCLK periods with FIFO_RRST=0; the bytes read are discarded. After the 4th sample_stb: FIFO_RRST<=1, state->RD_HI.
- RD_HI: on sample_stb, PIX_DATA[15:8]<=FIFO_DATA, state->RD_LO.
- RD_LO: on sample_stb, PIX_DATA[7:0]<=FIFO_DATA, PIX_VALID<=1, state->PUSH.
- First PIX_VALID rises on edge E0+12*RCLK_DIV.
- PUSH: RCLK held low; PIX_DATA, PIX_X and PIX_Y stable while PIX_VALID=1 and PIX_READY=0. On the edge with PIX_READY=1:
  - PIX_VALID<=0.
  - If PIX_X<H_PIX-1: PIX_X++, state->RD_HI.
  - Else PIX_X<=0. If PIX_Y<V_LINE-1: PIX_Y++, state->RD_HI.
  - Else (last pixel): PIX_Y<=0, state->DONE.
  - Coordinates update with PIX_VALID falling, so they always describe the pixel being presented.
- DONE, one cycle: FRAME_DONE<=1 (cleared next cycle), FIFO_OE<=1, R_IDLE<=1, state->IDLE.
- Per-pixel period with PIX_READY tied high: 4*RCLK_DIV+1 cycles.
- Widths: coordinate compares are at the full port width. Parameters outside their stated range are unsupported.

Decomposition:
- Shared package ov7670_pkg:
  - state encoding localparams IDLE=0, RRST=1, RD_HI=2, RD_LO=3, PUSH=4, DONE=5;
  - default H_PIX/V_LINE constants;
  - RRST_PERIODS=4.
- One sub-module, ov7670_rclk_gen. Inputs: enable, RCLK_DIV. Outputs: FIFO_RCLK and sample_stb. Resets to low/idle, with the phase counter cleared on disable.

Test Plan (H_PIX=4, V_LINE=2, RCLK_DIV=2, PIX_READY=1 unless stated):
- Reset, then WR_FRAME 0->1 at E0 -> R_IDLE=0 and FIFO_OE=0 at E0; FIFO_RRST low for exactly 16 cycles with 4 RCLK rises; first PIX_VALID at E0+24.
- FIFO model outputs bytes 0x00.. after pointer reset -> pixels 0x0001, 0x0203, ... 0x0E0F. Coordinates (0,0), (1,0), (2,0), (3,0), (0,1) ... (3,1). FRAME_DONE is a 1-cycle pulse one cycle after pixel (3,1) is accepted; R_IDLE=1 and FIFO_OE=1 on that same edge.
- PIX_READY low for 10 cycles during pixel (2,0) -> PIX_DATA/X/Y held, FIFO_RCLK stays low, no FIFO_DATA consumed; stream resumes with correct next pixel 0x0607.
- WR_FRAME falls and rises again mid-frame -> ignored; pixel count is still 8. WR_FRAME held high after DONE -> no restart.
- RST asserted in RD_LO of pixel (1,1) -> all outputs take reset values asynchronously. A new WR_FRAME rise restarts from the RRST sequence and pixel (0,0).
- RCLK_DIV=1 -> FIFO_RCLK period 2 cycles; first PIX_VALID at E0+12; all 8 pixels correct.
